// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states,
// iteration counts, the counter width and a magnitude helper.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          MULT_ITERS = 16;
  localparam int          DIV_ITERS  = 32;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam int          CNT_W      = 6;

  // Magnitude of a two's-complement word; 33 bits so that INT_MIN maps to 2^31.
  function automatic logic [32:0] mag33(input logic [31:0] v);
    logic [32:0] w_ext;
    w_ext = {v[31], v};
    return v[31] ? (33'd0 - w_ext) : w_ext;
  endfunction

endpackage

// File: rtl/multdiv_booth_step.sv
// One radix-4 Booth iteration on the 65-bit product register {A, Q, q-1}:
// recode the low three bits, add the selected multiple of M to A (34-bit
// arithmetic), then shift the whole register right arithmetically by two.
module multdiv_booth_step (
  input  logic [64:0] i_prod,
  input  logic [31:0] i_mcand,
  output logic [64:0] o_prod
);

  logic [33:0] w_m;
  logic [33:0] w_m2;
  logic [33:0] w_pp;
  logic [33:0] w_sum;
  logic [66:0] w_ext;

  // Recode, accumulate and shift; all combinational.
  always_comb begin
    // NOTE: every signal gets a value before the case so no path can infer a latch.
    w_pp  = '0;
    w_m   = {{2{i_mcand[31]}}, i_mcand};
    w_m2  = {w_m[32:0], 1'b0};
    case (i_prod[2:0])
      3'b001, 3'b010: w_pp = w_m;
      3'b011:         w_pp = w_m2;
      3'b100:         w_pp = 34'd0 - w_m2;
      3'b101, 3'b110: w_pp = 34'd0 - w_m;
      default:        w_pp = '0;
    endcase
    w_sum  = {{2{i_prod[64]}}, i_prod[64:33]} + w_pp;
    w_ext  = {w_sum, i_prod[32:0]};
    // Dropping the two LSBs of the sign-carrying 67-bit value is the >>> 2.
    o_prod = w_ext[66:2];
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiplier (radix-4 Booth, 16 steps) and divider
// (non-restoring on magnitudes, 32 steps) for the execute stage.
// Build option: define MULTDIV_DIV_EN to include the divide datapath; without
// it a divide request completes immediately with result 0 and exception 1.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [64:0]      r_prod;
  logic [31:0]      r_mcand;
  logic [31:0]      r_result;
  logic             r_exc;
  logic [64:0]      w_booth;

  multdiv_booth_step u_booth (
    .i_prod  (r_prod),
    .i_mcand (r_mcand),
    .o_prod  (w_booth)
  );

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == DONE);

`ifdef MULTDIV_DIV_EN
  logic [33:0] r_rem;
  logic [31:0] r_quo;
  logic [32:0] r_dvsr;
  logic        r_neg;
  logic        r_dz;
  logic        r_ovf;
  logic [32:0] w_mag_a;
  logic [32:0] w_mag_b;
  logic [33:0] w_rem_sh;
  logic [33:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_quo_fix;

  assign w_mag_a = mag33(data_operandA);
  assign w_mag_b = mag33(data_operandB);

  // One non-restoring step: shift {R,Q} left, add or subtract D by R's sign.
  always_comb begin
    w_rem_sh  = {r_rem[32:0], r_quo[31]};
    w_rem_nx  = r_rem[33] ? (w_rem_sh + {1'b0, r_dvsr})
                          : (w_rem_sh - {1'b0, r_dvsr});
    w_quo_nx  = {r_quo[30:0], ~w_rem_nx[33]};
    w_quo_fix = r_neg ? (32'd0 - w_quo_nx) : w_quo_nx;
  end
`endif

  // Control FSM, iteration counter and both datapaths.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
`ifdef MULTDIV_DIV_EN
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else if (ctrl_MULT) begin
      r_state <= MUL;
      r_cnt   <= '0;
      r_prod  <= {32'd0, data_operandB, 1'b0};
      r_mcand <= data_operandA;
    end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
      r_state <= DIV;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_mag_a[31:0];
      r_dvsr  <= w_mag_b;
      r_neg   <= data_operandA[31] ^ data_operandB[31];
      r_dz    <= (data_operandB == 32'd0);
      r_ovf   <= (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
`else
      r_state  <= DONE;
      r_cnt    <= '0;
      r_result <= 32'd0;
      r_exc    <= 1'b1;
`endif
    end else begin
      case (r_state)
        MUL: begin
          r_prod <= w_booth;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(MULT_ITERS - 1)) begin
            r_result <= w_booth[32:1];
            r_exc    <= (w_booth[64:33] != {32{w_booth[32]}});
            r_state  <= DONE;
          end
        end
`ifdef MULTDIV_DIV_EN
        DIV: begin
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
            // Restore the remainder; it is kept internally but not exported.
            r_rem   <= w_rem_nx[33] ? (w_rem_nx + {1'b0, r_dvsr}) : w_rem_nx;
            r_state <= DONE;
            if (r_dz) begin
              r_result <= 32'd0;
              r_exc    <= 1'b1;
            end else if (r_ovf) begin
              r_result <= INT_MIN;
              r_exc    <= 1'b1;
            end else begin
              r_result <= w_quo_fix;
              r_exc    <= 1'b0;
            end
          end else begin
            r_rem <= w_rem_nx;
          end
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
